// File: rtl/mem_debug_port.sv
// Debug-side master for the data memory interface port: turns UART command bytes
// into single-cycle memory strobes and streams results back through the UART transmitter.
module mem_debug_port #(
    parameter int ADDR_LENGTH    = 11,
    parameter int DATA_LENGTH    = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [1:0]             wr_rd,
    output logic [ADDR_LENGTH-1:0] addr,
    output logic [DATA_LENGTH-1:0] wdata,
    input  logic [DATA_LENGTH-1:0] rdata,
    output logic                   busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, GET_AH, GET_AL, GET_DH, GET_DL, GET_CNT,
        MEM_WR, MEM_RD, MEM_CAP, TX_H, TX_L, TX_ACK, TX_WAIT
    } state_t;

    state_t                 state_q, state_d, ret_q, ret_d;
    logic [7:0]             cmd_q, cmd_d, ah_q, ah_d, cnt_q, cnt_d;
    logic [TW-1:0]          to_q, to_d;
    logic                   first_q, first_d;
    logic [DATA_LENGTH-1:0] rd_q, rd_d;
    logic                   tx_start_q, tx_start_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic [1:0]             wr_rd_q, wr_rd_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [DATA_LENGTH-1:0] wdata_q, wdata_d;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        cmd_d      = cmd_q;
        ah_d       = ah_q;
        cnt_d      = cnt_q;
        to_d       = '0;
        first_d    = first_q;
        rd_d       = rd_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        wr_rd_d    = 2'b00;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            IDLE: if (rx_done) begin
                cmd_d   = rx_data;
                state_d = (rx_data == 8'h01 || rx_data == 8'h02 || rx_data == 8'h03) ? GET_AH : TX_ACK;
            end
            GET_AH: if (rx_done) begin
                ah_d    = rx_data;
                state_d = GET_AL;
            end
            GET_AL: if (rx_done) begin
                addr_d = ADDR_LENGTH'({ah_q, rx_data});
                case (cmd_q)
                    8'h01:   state_d = MEM_RD;
                    8'h02:   state_d = GET_DH;
                    default: state_d = GET_CNT;
                endcase
            end
            GET_DH: if (rx_done) begin
                wdata_d = {rx_data, wdata_q[7:0]};
                state_d = GET_DL;
            end
            GET_DL: if (rx_done) begin
                wdata_d = {wdata_q[15:8], rx_data};
                state_d = MEM_WR;
            end
            GET_CNT: if (rx_done) begin
                cnt_d   = rx_data;
                state_d = (rx_data == 8'h00) ? TX_ACK : MEM_RD;
            end
            MEM_WR:  state_d = TX_ACK;
            MEM_RD: begin
                rd_d    = rdata;
                state_d = MEM_CAP;
            end
            MEM_CAP: state_d = TX_H;
            TX_H: if (tx_start_q) begin
                ret_d   = TX_L;
                first_d = 1'b1;
                state_d = TX_WAIT;
            end
            TX_L: if (tx_start_q) begin
                if (cmd_q == 8'h01) begin
                    ret_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    ret_d = (cnt_q == 8'd1) ? TX_ACK : MEM_RD;
                end
                first_d = 1'b1;
                state_d = TX_WAIT;
            end
            TX_ACK: if (tx_start_q) begin
                ret_d   = IDLE;
                first_d = 1'b1;
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                // First cycle only gives tx_busy time to rise after tx_start.
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!tx_busy) begin
                    state_d = ret_q;
                    if (ret_q == MEM_RD)
                        addr_d = addr_q + {{(ADDR_LENGTH-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte timeout; the counter restarts on every received byte.
        if (state_q inside {GET_AH, GET_AL, GET_DH, GET_DL, GET_CNT} && !rx_done) begin
            if (to_q == TW'(TIMEOUT_CYCLES - 1))
                state_d = IDLE;
            else
                to_d = to_q + {{(TW-1){1'b0}}, 1'b1};
        end

        if (state_d == MEM_WR) wr_rd_d = 2'b10;
        if (state_d == MEM_RD) wr_rd_d = 2'b01;

        // A reply byte is launched on the edge entering (or while parked in) a TX state.
        if (state_d inside {TX_H, TX_L, TX_ACK} && !tx_busy) begin
            tx_start_d = 1'b1;
            case (state_d)
                TX_H:    tx_data_d = rd_q[15:8];
                TX_L:    tx_data_d = rd_q[7:0];
                default: tx_data_d = (cmd_d == 8'h02 || cmd_d == 8'h03) ? 8'hAA : 8'hEE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            cmd_q      <= '0;
            ah_q       <= '0;
            cnt_q      <= '0;
            to_q       <= '0;
            first_q    <= 1'b0;
            rd_q       <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            wr_rd_q    <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            cmd_q      <= cmd_d;
            ah_q       <= ah_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            first_q    <= first_d;
            rd_q       <= rd_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            wr_rd_q    <= wr_rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign wr_rd    = wr_rd_q;
    assign addr     = addr_q;
    assign wdata    = wdata_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_mem_debug_port.sv
// Directed bench for mem_debug_port with a behavioural memory and UART transmitter.
module tb_mem_debug_port;
    localparam int AL = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_done = 1'b0;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [1:0]    wr_rd;
    logic [AL-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   rdata = 16'h0000;
    logic          busy;

    mem_debug_port #(.ADDR_LENGTH(AL), .DATA_LENGTH(16), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .wr_rd(wr_rd), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rx_cyc = 0;
    int busy_len = 4;
    int busy_cnt = 0;
    int start_while_busy = 0;
    int unstable = 0;
    bit check_stable = 1'b0;
    logic [7:0]  cur_byte = 8'h00;
    logic [15:0] mem [0:(1<<AL)-1];
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    logic [28:0] ev_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: acts on the negedge following the strobe posedge.
    always @(negedge clk) begin
        if (wr_rd != 2'b00) ev_q.push_back({wr_rd, addr, wdata});
        if (wr_rd == 2'b10) mem[addr] = wdata;
        if (wr_rd == 2'b01) rdata = mem[addr];
    end

    // Transmitter: latches the byte on tx_start and stays busy for busy_len cycles.
    always @(negedge clk) begin
        if (tx_start) begin
            if (tx_busy) start_while_busy++;
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
            cur_byte = tx_data;
            tx_busy  = 1'b1;
            busy_cnt = busy_len;
        end else if (tx_busy) begin
            if (check_stable && tx_data !== cur_byte) unstable++;
            busy_cnt--;
            if (busy_cnt <= 0) tx_busy = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        rx_cyc  = cyc;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_logs();
        tx_q.delete();
        tx_cyc_q.delete();
        ev_q.delete();
    endtask

    task automatic wait_reply(input int n, input int limit);
        int k = 0;
        while ((tx_q.size() < n || busy) && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        n_cmp++;
        if (k >= limit) begin
            n_bad++;
            $display("FAIL reply_wait: got %0d bytes busy=%b, required %0d bytes and idle", tx_q.size(), busy, n);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL rst_tx_start: got %b required 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
        n_cmp++; if (wr_rd !== 2'b00) begin n_bad++; $display("FAIL rst_wr_rd: got %b required 00", wr_rd); end
        n_cmp++; if (addr !== '0) begin n_bad++; $display("FAIL rst_addr: got %h required 0", addr); end
        n_cmp++; if (wdata !== 16'h0) begin n_bad++; $display("FAIL rst_wdata: got %h required 0", wdata); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    endtask

    task automatic test_write_read();
        clear_logs();
        send_byte(8'h02);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_rise: got %b required 1", busy); end
        send_byte(8'h00); send_byte(8'h05); send_byte(8'hBE); send_byte(8'hEF);
        wait_reply(1, 500);
        n_cmp++; if (ev_q.size() != 1) begin n_bad++; $display("FAIL wr_pulses: got %0d required 1", ev_q.size()); end
        else begin
            n_cmp++; if (ev_q[0] !== {2'b10, 11'd5, 16'hBEEF}) begin n_bad++; $display("FAIL wr_strobe: got %h required %h", ev_q[0], {2'b10, 11'd5, 16'hBEEF}); end
        end
        n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== 8'hAA) begin n_bad++; $display("FAIL wr_ack: got %0d bytes first %h required 1 byte AA", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00); end
        if (tx_cyc_q.size() > 0) begin
            n_cmp++; if (tx_cyc_q[0] - rx_cyc != 2) begin n_bad++; $display("FAIL wr_latency: got %0d required 2", tx_cyc_q[0] - rx_cyc); end
        end
        n_cmp++; if (mem[5] !== 16'hBEEF) begin n_bad++; $display("FAIL wr_mem: got %h required BEEF", mem[5]); end

        clear_logs();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        wait_reply(2, 500);
        n_cmp++; if (tx_q.size() != 2 || tx_q[0] !== 8'hBE || tx_q[1] !== 8'hEF) begin n_bad++; $display("FAIL rd_reply: got %0d bytes, required BE EF", tx_q.size()); end
        n_cmp++; if (ev_q.size() != 1 || ev_q[0][28:16] !== {2'b01, 11'd5}) begin n_bad++; $display("FAIL rd_strobe: got %0d pulses, required one read of addr 5", ev_q.size()); end
        if (tx_cyc_q.size() > 0) begin
            n_cmp++; if (tx_cyc_q[0] - rx_cyc != 3) begin n_bad++; $display("FAIL rd_latency: got %0d required 3", tx_cyc_q[0] - rx_cyc); end
        end
    endtask

    task automatic test_dump();
        logic [7:0] exp [9];
        exp = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'hAA};
        for (int i = 0; i < 4; i++) mem[i] = 16'(i + 1);
        clear_logs();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
        wait_reply(9, 2000);
        n_cmp++; if (tx_q.size() != 9) begin n_bad++; $display("FAIL dump_len: got %0d required 9", tx_q.size()); end
        for (int i = 0; i < 9 && i < tx_q.size(); i++) begin
            n_cmp++; if (tx_q[i] !== exp[i]) begin n_bad++; $display("FAIL dump_byte%0d: got %h required %h", i, tx_q[i], exp[i]); end
        end
        n_cmp++; if (ev_q.size() != 4) begin n_bad++; $display("FAIL dump_pulses: got %0d required 4", ev_q.size()); end
        for (int i = 0; i < 4 && i < ev_q.size(); i++) begin
            n_cmp++; if (ev_q[i][28:16] !== {2'b01, 11'(i)}) begin n_bad++; $display("FAIL dump_addr%0d: got %h required %h", i, ev_q[i][28:16], {2'b01, 11'(i)}); end
        end
    endtask

    task automatic test_dump_wrap();
        logic [7:0] exp [5];
        exp = '{8'h12, 8'h34, 8'h00, 8'h01, 8'hAA};
        mem[2047] = 16'h1234;
        clear_logs();
        send_byte(8'h03); send_byte(8'h07); send_byte(8'hFF); send_byte(8'h02);
        wait_reply(5, 2000);
        n_cmp++; if (tx_q.size() != 5) begin n_bad++; $display("FAIL wrap_len: got %0d required 5", tx_q.size()); end
        for (int i = 0; i < 5 && i < tx_q.size(); i++) begin
            n_cmp++; if (tx_q[i] !== exp[i]) begin n_bad++; $display("FAIL wrap_byte%0d: got %h required %h", i, tx_q[i], exp[i]); end
        end
        n_cmp++; if (ev_q.size() != 2 || ev_q[0][26:16] !== 11'h7FF || ev_q[1][26:16] !== 11'h000) begin n_bad++; $display("FAIL wrap_addr: got %0d pulses, required reads at 7ff then 000", ev_q.size()); end

        clear_logs();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_reply(1, 500);
        n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== 8'hAA) begin n_bad++; $display("FAIL dump0_reply: got %0d bytes, required AA only", tx_q.size()); end
        n_cmp++; if (ev_q.size() != 0) begin n_bad++; $display("FAIL dump0_pulses: got %0d required 0", ev_q.size()); end
    endtask

    task automatic test_error_timeout();
        clear_logs();
        send_byte(8'h55);
        wait_reply(1, 500);
        n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== 8'hEE) begin n_bad++; $display("FAIL err_reply: got %0d bytes, required EE", tx_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL err_busy: got %b required 0", busy); end

        clear_logs();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL to_pending: got busy %b required 1", busy); end
        repeat (80) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_idle: got busy %b required 0", busy); end
        n_cmp++; if (ev_q.size() != 0 || tx_q.size() != 0) begin n_bad++; $display("FAIL to_quiet: got %0d pulses %0d bytes, required 0 and 0", ev_q.size(), tx_q.size()); end
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        wait_reply(2, 500);
        n_cmp++; if (tx_q.size() != 2 || tx_q[0] !== 8'hBE || tx_q[1] !== 8'hEF) begin n_bad++; $display("FAIL to_read: got %0d bytes, required BE EF", tx_q.size()); end
    endtask

    task automatic test_reset_mid_dump();
        int k = 0;
        int seen;
        for (int i = 0; i < 4; i++) mem[i] = 16'(i + 1);
        clear_logs();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
        while (tx_q.size() < 5 && k < 2000) begin @(negedge clk); k++; end
        n_cmp++; if (k >= 2000) begin n_bad++; $display("FAIL mid_reach: got %0d bytes required 5", tx_q.size()); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_start !== 1'b0 || wr_rd !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctl: got start %b wr_rd %b busy %b required 0 00 0", tx_start, wr_rd, busy); end
        n_cmp++; if (tx_data !== 8'h00 || addr !== '0 || wdata !== 16'h0) begin n_bad++; $display("FAIL mid_rst_data: got %h %h %h required 00 000 0000", tx_data, addr, wdata); end
        seen = tx_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        #1;
        n_cmp++; if (tx_q.size() != seen) begin n_bad++; $display("FAIL mid_no_tx: got %0d bytes required %0d", tx_q.size(), seen); end
        clear_logs();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        wait_reply(2, 500);
        n_cmp++; if (tx_q.size() != 2 || tx_q[0] !== 8'hBE || tx_q[1] !== 8'hEF) begin n_bad++; $display("FAIL mid_read: got %0d bytes, required BE EF", tx_q.size()); end
    endtask

    task automatic test_slow_tx();
        busy_len = 100;
        start_while_busy = 0;
        unstable = 0;
        check_stable = 1'b1;
        clear_logs();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        wait_reply(2, 1000);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h07); send_byte(8'h12); send_byte(8'h34);
        wait_reply(3, 1000);
        n_cmp++; if (tx_q.size() != 3 || tx_q[0] !== 8'hBE || tx_q[1] !== 8'hEF || tx_q[2] !== 8'hAA) begin n_bad++; $display("FAIL slow_order: got %0d bytes, required BE EF AA", tx_q.size()); end
        n_cmp++; if (start_while_busy != 0) begin n_bad++; $display("FAIL slow_overlap: got %0d required 0", start_while_busy); end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL slow_stable: got %0d changes required 0", unstable); end
        n_cmp++; if (mem[7] !== 16'h1234) begin n_bad++; $display("FAIL slow_mem: got %h required 1234", mem[7]); end
        check_stable = 1'b0;
        busy_len = 4;
    endtask

    initial begin
        for (int i = 0; i < (1 << AL); i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_write_read();
        test_dump();
        test_dump_wrap();
        test_error_timeout();
        test_reset_mid_dump();
        test_slow_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
